// File: rtl/instr_decode.sv
// instr_decode: RV32I OP / OP-IMM decode stage with a 2-entry skid buffer.
// Incoming words are decoded combinationally, then parked in either the
// output register or the skid register so both handshakes are registered.
module instr_decode #(
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [4:0]         rd,
    output logic [2:0]         alu_op,
    output logic [31:0]        imm,
    output logic               use_imm,
    output logic               rd_we,
    output logic               illegal,
    output logic [COUNT_W-1:0] illegal_count
);

    // ALU_OP codes
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_SLL = 3'd2;
    localparam logic [2:0] ALU_XOR = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_AND = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SRA = 3'd7;

    // RTYPE funct7 codes
    localparam logic [6:0] RTYPE_RA = 7'b0000000;
    localparam logic [6:0] RTYPE_RB = 7'b0100000;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  alu_op;
        logic [31:0] imm;
        logic        use_imm;
        logic        rd_we;
        logic        illegal;
    } bundle_t;

    bundle_t            dec;
    bundle_t            out_q, out_d;
    bundle_t            skid_q, skid_d;
    logic               out_valid_q, out_valid_d;
    logic               skid_valid_q, skid_valid_d;
    logic               in_ready_q, in_ready_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_op;
    logic       is_imm;
    logic       legal;
    logic [2:0] op_sel;
    logic       accept;
    logic       xfer;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign is_op  = (opcode == OPC_OP);
    assign is_imm = (opcode == OPC_OP_IMM);

    // in_ready mirrors the registered "skid empty" state, so accept never
    // lands on an occupied skid entry.
    assign accept = in_valid && in_ready_q;
    assign xfer   = out_valid_q && out_ready;

    // Decode the incoming word; funct7 is only significant where it selects
    // the operation (OP, and the shift encodings of OP-IMM).
    always_comb begin
        legal  = 1'b0;
        op_sel = ALU_ADD;
        if (is_op || is_imm) begin
            case (funct3)
                3'b000: begin
                    if (is_imm || funct7 == RTYPE_RA) begin
                        legal  = 1'b1;
                        op_sel = ALU_ADD;
                    end else if (funct7 == RTYPE_RB) begin
                        legal  = 1'b1;
                        op_sel = ALU_SUB;
                    end
                end
                3'b001: begin
                    legal  = (funct7 == RTYPE_RA);
                    op_sel = ALU_SLL;
                end
                3'b100: begin
                    legal  = is_imm || (funct7 == RTYPE_RA);
                    op_sel = ALU_XOR;
                end
                3'b110: begin
                    legal  = is_imm || (funct7 == RTYPE_RA);
                    op_sel = ALU_OR;
                end
                3'b111: begin
                    legal  = is_imm || (funct7 == RTYPE_RA);
                    op_sel = ALU_AND;
                end
                3'b101: begin
                    if (funct7 == RTYPE_RA) begin
                        legal  = 1'b1;
                        op_sel = ALU_SRL;
                    end else if (funct7 == RTYPE_RB) begin
                        legal  = 1'b1;
                        op_sel = ALU_SRA;
                    end
                end
                // SLT/SLTU have no 3-bit ALU code
                default: legal = 1'b0;
            endcase
        end

        dec         = '0;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.rd      = instr[11:7];
        dec.alu_op  = ALU_ADD;
        dec.illegal = !legal;
        if (legal) begin
            dec.alu_op  = op_sel;
            dec.use_imm = is_imm;
            dec.imm     = is_imm ? {{20{instr[31]}}, instr[31:20]} : 32'd0;
            dec.rs2     = is_imm ? 5'd0 : instr[24:20];
            dec.rd_we   = (instr[11:7] != 5'd0);
        end
    end

    // Next-state for output/skid entries and the illegal counter.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (!out_valid_q || xfer) begin
                // Output slot frees up: refill from skid first to keep order.
                if (skid_valid_q) begin
                    out_d        = skid_q;
                    out_valid_d  = 1'b1;
                    skid_valid_d = 1'b0;
                end else if (accept) begin
                    out_d       = dec;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (accept) begin
                // Output stalled: park the new word in skid.
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end

            if (accept && dec.illegal && (cnt_q != {COUNT_W{1'b1}})) begin
                cnt_d = cnt_q + {{(COUNT_W-1){1'b0}}, 1'b1};
            end
        end

        in_ready_d = !skid_valid_d;
    end

    // State registers; reset overrides flush and handshakes.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            cnt_q        <= '0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign rs1           = out_q.rs1;
    assign rs2           = out_q.rs2;
    assign rd            = out_q.rd;
    assign alu_op        = out_q.alu_op;
    assign imm           = out_q.imm;
    assign use_imm       = out_q.use_imm;
    assign rd_we         = out_q.rd_we;
    assign illegal       = out_q.illegal;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_instr_decode.sv
// Scoreboard bench for instr_decode: the driver pushes hand-computed bundles
// on accept, a monitor pops and compares on every output transfer.
module tb_instr_decode;

    localparam int COUNT_W = 16;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_SLL = 3'd2;
    localparam logic [2:0] ALU_XOR = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_AND = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SRA = 3'd7;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  alu_op;
        logic [31:0] imm;
        logic        use_imm;
        logic        rd_we;
        logic        illegal;
    } b_t;

    typedef struct {
        b_t b;
        int acc;
        bit lat;
    } exp_t;

    logic               clock = 1'b0;
    logic               reset;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        instr;
    logic               out_valid;
    logic               out_ready;
    logic [4:0]         rs1, rs2, rd;
    logic [2:0]         alu_op;
    logic [31:0]        imm;
    logic               use_imm, rd_we, illegal;
    logic [COUNT_W-1:0] illegal_count;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   lat_mode = 0;
    exp_t sb[$];

    instr_decode #(.COUNT_W(COUNT_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .alu_op(alu_op), .imm(imm),
        .use_imm(use_imm), .rd_we(rd_we), .illegal(illegal),
        .illegal_count(illegal_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic b_t mk(input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] d, input logic [2:0] op,
                              input logic [31:0] im, input logic ui,
                              input logic we, input logic il);
        b_t b;
        b.rs1 = s1; b.rs2 = s2; b.rd = d; b.alu_op = op; b.imm = im;
        b.use_imm = ui; b.rd_we = we; b.illegal = il;
        return b;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compare every transfer against the scoreboard head.
    initial begin
        exp_t e;
        b_t   got;
        forever begin
            @(negedge clock);
            if (!reset && out_valid && out_ready) begin
                got = {rs1, rs2, rd, alu_op, imm, use_imm, rd_we, illegal};
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none", got);
                end else begin
                    e = sb.pop_front();
                    chk("bundle", 64'(got), 64'(e.b));
                    if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd1);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Present a word until accepted (bounded) and queue its expected bundle.
    task automatic send(input logic [31:0] w, input b_t e);
        bit   got = 0;
        exp_t x;
        in_valid = 1'b1;
        instr    = w;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (in_ready) begin
                got   = 1;
                x.b   = e;
                x.acc = cyc;
                x.lat = lat_mode;
                if (!flush) sb.push_back(x);
            end
            @(posedge clock);
            #1;
        end
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
        step(3);
        // An illegal word offered during reset must not be counted.
        in_valid = 1'b1;
        step(2);
        @(negedge clock);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_count", 64'(illegal_count), 64'd0);
        chk("rst_fields", 64'({rs1, rs2, rd, alu_op, imm, use_imm, rd_we, illegal}), 64'd0);
        @(posedge clock); #1;
        in_valid = 1'b0;
        reset    = 1'b0;
        step(1);

        // Back-to-back R-type
        lat_mode = 1;
        send(32'h002081B3, mk(1, 2, 3, ALU_ADD, 0, 0, 1, 0));
        send(32'h402081B3, mk(1, 2, 3, ALU_SUB, 0, 0, 1, 0));
        send(32'h4020D1B3, mk(1, 2, 3, ALU_SRA, 0, 0, 1, 0));
        in_valid = 1'b0;
        step(3);

        // addi x5,x0,-1
        send(32'hFFF00293, mk(0, 0, 5, ALU_ADD, 32'hFFFFFFFF, 1, 1, 0));
        in_valid = 1'b0;
        step(2);

        // slt and all-zero word are illegal
        send(32'h0020A1B3, mk(1, 2, 3, ALU_ADD, 0, 0, 0, 1));
        send(32'h00000000, mk(0, 0, 0, ALU_ADD, 0, 0, 0, 1));
        in_valid = 1'b0;
        step(2);
        @(negedge clock);
        chk("count_after_slt", 64'(illegal_count), 64'd2);
        @(posedge clock); #1;

        // slli x8,x1,3 ; slli with bad funct7 ; add x0,x1,x2 (no write-back)
        send(32'h00309413, mk(1, 0, 8, ALU_SLL, 32'd3, 1, 1, 0));
        send(32'h02309413, mk(1, 3, 8, ALU_ADD, 0, 0, 0, 1));
        send(32'h00208033, mk(1, 2, 0, ALU_ADD, 0, 0, 0, 0));
        in_valid = 1'b0;
        step(2);
        @(negedge clock);
        chk("count_after_slli", 64'(illegal_count), 64'd3);
        @(posedge clock); #1;
        lat_mode = 0;

        // Back-pressure: only two words fit while out_ready=0
        out_ready = 1'b0;
        send(32'h0020C233, mk(1, 2, 4, ALU_XOR, 0, 0, 1, 0));
        send(32'h0020E2B3, mk(1, 2, 5, ALU_OR,  0, 0, 1, 0));
        in_valid = 1'b1;
        instr    = 32'h0020F333;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            @(posedge clock); #1;
        end
        @(negedge clock);
        chk("bp_held_rd", 64'({out_valid, rd}), 64'({1'b1, 5'd4}));
        @(posedge clock); #1;
        out_ready = 1'b1;
        send(32'h0020F333, mk(1, 2, 6, ALU_AND, 0, 0, 1, 0));
        send(32'h0020D3B3, mk(1, 2, 7, ALU_SRL, 0, 0, 1, 0));
        in_valid = 1'b0;
        step(4);
        @(negedge clock);
        chk("bp_in_ready_high", 64'(in_ready), 64'd1);
        chk("bp_drained", 64'(sb.size()), 64'd0);
        @(posedge clock); #1;

        // Flush with both entries full: neither word may appear.
        out_ready = 1'b0;
        send(32'h0020C233, mk(1, 2, 4, ALU_XOR, 0, 0, 1, 0));
        send(32'h0020E2B3, mk(1, 2, 5, ALU_OR,  0, 0, 1, 0));
        in_valid = 1'b0;
        @(negedge clock);
        chk("fl_full", 64'(in_ready), 64'd0);
        @(posedge clock); #1;
        flush = 1'b1;
        sb.delete();
        step(1);
        flush = 1'b0;
        @(negedge clock);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        @(posedge clock); #1;
        out_ready = 1'b1;
        step(3);

        // Word accepted during flush is dropped and not counted.
        flush = 1'b1; in_valid = 1'b1; instr = 32'h00000000;
        step(1);
        flush = 1'b0; in_valid = 1'b0;
        step(3);
        @(negedge clock);
        chk("fl_count_kept", 64'(illegal_count), 64'd3);
        chk("fl_no_output", 64'(out_valid), 64'd0);
        @(posedge clock); #1;

        for (int i = 0; i < 20 && sb.size() != 0; i++) step(1);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_decode.md
# instr_decode

Registered instruction-decode stage for the RV32I pipeline. It accepts 32-bit instruction words over a valid/ready handshake and decodes OP (R-type) and OP-IMM (I-type) ALU instructions into the register addresses, the `ALU_OP` code, the immediate and the control flags. The result goes to the execute stage through a 2-entry skid buffer, so both handshakes stay fully registered. It is the inverse of the R-type instruction encoding used to drive the `mpu` in simulation, and it uses the `ALU_OP` and `RTYPE` package codes.

## Interface
- `COUNT_W`, default 16: width of the illegal-instruction counter.
- `clock` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: discard all buffered instructions.
- `in_valid` in 1: `instr` is valid.
- `in_ready` out 1: the stage can accept `instr`.
- `instr` in 32: RV32I instruction word.
- `out_valid` out 1: the decoded bundle is valid.
- `out_ready` in 1: execute consumes the bundle.
- `rs1` out 5: `instr[19:15]`.
- `rs2` out 5: `instr[24:20]`. Forced to 0 for OP-IMM.
- `rd` out 5: `instr[11:7]`.
- `alu_op` out 3: `ALU_OP` code.
- `imm` out 32: sign-extended `instr[31:20]`. 0 for OP.
- `use_imm` out 1: operand B is `imm`.
- `rd_we` out 1: write back. 0 if illegal or `rd`==0.
- `illegal` out 1: unsupported or unknown encoding.
- `illegal_count` out `COUNT_W`: saturating count of accepted illegal instructions.

## Operation
- Accept occurs when `in_valid && in_ready`. Transfer out occurs when `out_valid && out_ready`.
- OP (opcode `0110011`):
  - funct3 000 with funct7 `RTYPE::RA` → `ALU_ADD`; with `RTYPE::RB` → `ALU_SUB`.
  - funct3 001 → `ALU_SLL`. Requires funct7 RA.
  - funct3 100 → `ALU_XOR`, 110 → `ALU_OR`, 111 → `ALU_AND`. Each requires funct7 RA.
  - funct3 101 with funct7 RA → `ALU_SRL`; with RB → `ALU_SRA`.
  - funct3 010/011 (SLT/SLTU) are illegal: no 3-bit code exists for them.
  - Any other funct7 is illegal.
- OP-IMM (opcode `0010011`):
  - Same funct3 map as OP, with `use_imm`=1.
  - funct3 000 is always `ALU_ADD`; funct7 is ignored because it is part of the immediate.
  - funct3 001 and 101 decode funct7 exactly as OP does.
  - funct3 010/011 are illegal.
- Illegal bundles:
  - All other opcodes are illegal.
  - An illegal bundle still transfers with `alu_op`=`ALU_ADD`, `use_imm`=0, `imm`=0, `rd_we`=0. `rs1`/`rs2`/`rd` are the raw fields.
  - `illegal_count` increments once per accepted illegal word and saturates at all-ones.
- Buffering:
  - One output register plus one skid register.
  - `in_ready` = !`skid_valid`, driven from a register.
  - When the output register is full and not being drained, an accepted word goes to the skid register.
  - When the output drains, the skid contents move to the output register.
- Flush:
  - `flush`=1 clears both valid bits next cycle.
  - A word accepted in the flush cycle is dropped and not counted.
  - `illegal_count` is not cleared by flush.

## Timing
- Reset values: `out_valid`=0, `in_ready`=1, `illegal_count`=0, all bundle fields 0.
- Reset wins over `flush` and over any handshake in the same cycle.
- Latency: an instruction accepted at edge N is presented with `out_valid`=1 after edge N.
- Throughput is 1 instruction/cycle while `out_ready`=1.
- Back-pressure:
  - With `out_ready`=0, one further word is accepted into skid.
  - `in_ready` falls the cycle after skid fills.
- Simultaneous accept and transfer with the output full and skid empty: the new word goes directly to the output register. Skid stays empty.
- Order is strictly FIFO; no word is dropped or duplicated except by flush.
- Bundle fields are held stable while `out_valid && !out_ready`.

## Test plan
- Reset held 5 cycles → `out_valid`=0, `in_ready`=1, `illegal_count`=0.
- Back-to-back `0x002081B3`, `0x402081B3`, `0x4020D1B3` with `out_ready`=1:
  - Outputs on 3 consecutive cycles, one cycle after each accept.
  - `alu_op` = ADD, SUB, SRA.
  - Each has `rs1`=1, `rs2`=2, `rd`=3, `rd_we`=1.
- `0xFFF00293` (addi x5,x0,-1) → `ALU_ADD`, `use_imm`=1, `imm`=`0xFFFFFFFF`, `rs1`=0, `rd`=5, `rd_we`=1.
- `0x0020A1B3` (slt) then `0x00000000`:
  - Both bundles have `illegal`=1 and `rd_we`=0.
  - `illegal_count`=2.
- Back-pressure:
  - `out_ready`=0 while streaming 4 words → only 2 accepted and `in_ready`=0.
  - Then `out_ready`=1 → the words emerge in order and `in_ready` returns high.
- `flush` with both entries full → `out_valid`=0 next cycle, `in_ready`=1, and neither word appears.
